// File: rtl/ahb_pkg.sv
// Shared encodings for the AHB-style interconnect: slave response codes and
// arbiter phase encoding.
package ahb_pkg;

    typedef enum logic [1:0] {
        HRESP_OKAY  = 2'b00,
        HRESP_ERROR = 2'b01,
        HRESP_RETRY = 2'b10,
        HRESP_SPLIT = 2'b11
    } hresp_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ADDR = 2'b01,
        ST_DATA = 2'b10
    } arb_state_e;

    localparam int MAX_N_MASTERS = 8;

endpackage

// File: rtl/ahb_arbiter_n_arb_pick.sv
// Combinational winner select: first eligible, non-excluded master found when
// searching upward from rr_ptr (modulo N_MASTERS). rr_ptr = 0 gives fixed priority.
module arb_pick #(
    parameter int N_MASTERS = 2,
    localparam int IDW = $clog2(N_MASTERS)
) (
    input  logic [N_MASTERS-1:0] elig,
    input  logic [N_MASTERS-1:0] excl,
    input  logic [IDW-1:0]       rr_ptr,
    output logic [N_MASTERS-1:0] win_onehot,
    output logic [IDW-1:0]       win_id,
    output logic                 valid
);

    logic [N_MASTERS-1:0] cand_s;
    logic [IDW:0]         sum_s;
    logic [IDW:0]         idx_s;

    assign cand_s = elig & ~excl;

    // Scan candidates in priority order starting at rr_ptr; the first hit wins.
    always_comb begin
        win_onehot = '0;
        win_id     = '0;
        valid      = 1'b0;
        sum_s      = '0;
        idx_s      = '0;
        for (int k = 0; k < N_MASTERS; k++) begin
            sum_s = {1'b0, rr_ptr} + (IDW+1)'(k);
            idx_s = (sum_s >= (IDW+1)'(N_MASTERS)) ? (sum_s - (IDW+1)'(N_MASTERS)) : sum_s;
            if (!valid && cand_s[idx_s[IDW-1:0]]) begin
                valid                         = 1'b1;
                win_id                        = idx_s[IDW-1:0];
                win_onehot[idx_s[IDW-1:0]]    = 1'b1;
            end else begin
                valid = valid;
            end
        end
    end

endmodule

// File: rtl/ahb_arbiter_n.sv
// N-master AHB-style bus arbiter with SPLIT parking, tenure beat limit and
// re-arbitration on ERROR/RETRY/SPLIT. Define ARB_ROUND_ROBIN_EN for round-robin selection.
module ahb_arbiter_n
    import ahb_pkg::*;
#(
    parameter int N_MASTERS = 2,
    parameter int MAX_BEATS = 4,
    localparam int IDW = $clog2(N_MASTERS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_MASTERS-1:0] busreq,
    input  logic                 hready,
    input  logic [1:0]           hresp,
    input  logic [N_MASTERS-1:0] split_clr,
    output logic [N_MASTERS-1:0] grant,
    output logic [IDW-1:0]       grant_id,
    output logic                 bus_busy,
    output logic [N_MASTERS-1:0] split_mask
);

    localparam int BW = $clog2(MAX_BEATS + 1);

    arb_state_e           state_r;
    logic [N_MASTERS-1:0] grant_r;
    logic [IDW-1:0]       grant_id_r;
    logic                 bus_busy_r;
    logic [N_MASTERS-1:0] split_mask_r;
    logic [BW-1:0]        beat_cnt_r;
    logic [IDW-1:0]       rr_ptr_s;

    hresp_e               hresp_s;
    logic [N_MASTERS-1:0] elig_s;
    logic [N_MASTERS-1:0] excl_s;
    logic [N_MASTERS-1:0] split_set_s;
    logic [BW-1:0]        beat_nxt_s;
    logic                 stay_s;
    logic                 rearb_s;
    logic                 okay_fallback_s;
    logic [N_MASTERS-1:0] win_oh_s;
    logic [IDW-1:0]       win_id_s;
    logic                 win_vld_s;
    logic [N_MASTERS-1:0] next_oh_s;
    logic [IDW-1:0]       next_id_s;
    logic                 next_vld_s;

`ifdef ARB_ROUND_ROBIN_EN
    logic [IDW-1:0]       rr_ptr_r;
    assign rr_ptr_s = rr_ptr_r;
`else
    assign rr_ptr_s = '0;
`endif

    assign hresp_s    = hresp_e'(hresp);
    assign elig_s     = busreq & ~split_mask_r;
    assign beat_nxt_s = beat_cnt_r + BW'(1);
    assign stay_s     = ((busreq & grant_r) != '0) && (beat_nxt_s < BW'(MAX_BEATS));

    // Decide whether this cycle re-arbitrates and which master is kept out of it.
    always_comb begin
        excl_s          = '0;
        split_set_s     = '0;
        rearb_s         = 1'b0;
        okay_fallback_s = 1'b0;
        case (state_r)
            ST_IDLE: rearb_s = 1'b1;
            ST_DATA: begin
                if (hready) begin
                    case (hresp_s)
                        HRESP_OKAY: begin
                            excl_s          = grant_r;
                            rearb_s         = !stay_s;
                            okay_fallback_s = 1'b1;
                        end
                        HRESP_ERROR: begin
                            excl_s  = grant_r;
                            rearb_s = 1'b1;
                        end
                        HRESP_RETRY: rearb_s = 1'b1;
                        HRESP_SPLIT: begin
                            excl_s      = grant_r;
                            split_set_s = grant_r;
                            rearb_s     = 1'b1;
                        end
                        default: rearb_s = 1'b1;
                    endcase
                end else begin
                    rearb_s = 1'b0;
                end
            end
            default: rearb_s = 1'b0;
        endcase
    end

    arb_pick #(
        .N_MASTERS (N_MASTERS)
    ) u_arb_pick (
        .elig       (elig_s),
        .excl       (excl_s),
        .rr_ptr     (rr_ptr_s),
        .win_onehot (win_oh_s),
        .win_id     (win_id_s),
        .valid      (win_vld_s)
    );

    // A tenure ended by the beat limit falls back to the same owner when nobody else asks.
    always_comb begin
        next_oh_s  = win_oh_s;
        next_id_s  = win_id_s;
        next_vld_s = win_vld_s;
        if (!win_vld_s && okay_fallback_s && ((elig_s & grant_r) != '0)) begin
            next_oh_s  = grant_r;
            next_id_s  = grant_id_r;
            next_vld_s = 1'b1;
        end else begin
            next_vld_s = win_vld_s;
        end
    end

    // Arbiter FSM with registered grant outputs, beat counter and split parking.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            grant_r      <= '0;
            grant_id_r   <= '0;
            bus_busy_r   <= 1'b0;
            split_mask_r <= '0;
            beat_cnt_r   <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            rr_ptr_r     <= '0;
`endif
        end else begin
            // A SPLIT set beats a same-cycle release for the same master.
            split_mask_r <= (split_mask_r & ~split_clr) | split_set_s;
            if (rearb_s) begin
                if (next_vld_s) begin
                    state_r    <= ST_ADDR;
                    grant_r    <= next_oh_s;
                    grant_id_r <= next_id_s;
                    bus_busy_r <= 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
                    rr_ptr_r   <= (next_id_s == IDW'(N_MASTERS - 1)) ? '0 : next_id_s + IDW'(1);
`endif
                end else begin
                    state_r    <= ST_IDLE;
                    grant_r    <= '0;
                    bus_busy_r <= 1'b0;
                end
            end else begin
                case (state_r)
                    ST_ADDR: begin
                        if (hready) begin
                            state_r    <= ST_DATA;
                            beat_cnt_r <= '0;
                        end else begin
                            state_r    <= ST_ADDR;
                        end
                    end
                    ST_DATA: begin
                        if (hready) begin
                            beat_cnt_r <= beat_nxt_s;
                        end else begin
                            beat_cnt_r <= beat_cnt_r;
                        end
                    end
                    ST_IDLE: state_r <= ST_IDLE;
                    default: begin
                        state_r    <= ST_IDLE;
                        grant_r    <= '0;
                        bus_busy_r <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign grant      = grant_r;
    assign grant_id   = grant_id_r;
    assign bus_busy   = bus_busy_r;
    assign split_mask = split_mask_r;

endmodule

// File: doc/ahb_arbiter_n.md
Name: ahb_arbiter_n

Overview:
- Parametrised bus arbiter for the multi-master AHB-style interconnect; generalises the current two-master arbiter (busreq_1/busreq_2, grant_1/grant_2) to N masters.
- Adds per-master SPLIT masking with slave-driven release, a tenure beat limit, and re-arbitration on ERROR/RETRY/SPLIT responses.
- Sits between the master request lines and the address/data mux selects in data_path. grant_id drives those mux selects directly.

Parameters:
- N_MASTERS, 2, number of masters (2..8).
- MAX_BEATS, 4, maximum OKAY data beats per tenure before forced re-arbitration (1..16).
- IDW, $clog2(N_MASTERS), width of grant_id (derived, not overridden).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- busreq  in  N_MASTERS  bus request per master, bit 0 = master 0.
- hready  in  1  selected slave ready (the muxed rdyout).
- hresp  in  2  selected slave response: 00 OKAY, 01 ERROR, 10 RETRY, 11 SPLIT.
- split_clr  in  N_MASTERS  slave request to release a split master.
- grant  out  N_MASTERS  one-hot grant, or all-zero.
- grant_id  out  IDW  index of the granted master.
- bus_busy  out  1  high in ADDR or DATA.
- split_mask  out  N_MASTERS  masters currently parked by SPLIT.

Behaviour:
- Clock and reset: single clock clk; rst is synchronous and active-high. Reset is sampled on the rising edge of clk and forces:
  - state = IDLE
  - grant = 0, grant_id = 0, bus_busy = 0
  - split_mask = 0, beat_cnt = 0, rr_ptr = 0
- Eligible set: elig = busreq & ~split_mask.
- Selection (combinational, in arb_pick):
  - Fixed priority by default: lowest index wins.
  - The owner is excluded from its own re-arbitration, except in the RETRY and beat-limit cases below.
- All outputs are registered. A request sampled in cycle n gives a grant visible in cycle n+1.
- State IDLE:
  - grant = 0.
  - If elig != 0: register the winner and go to ADDR.
- State ADDR: one address-phase cycle.
  - hready = 1: go to DATA, beat_cnt = 0.
  - hready = 0: hold.
- State DATA: hready = 0 holds all state, grant and counters (wait states).
- DATA with hready = 1:
  - OKAY: beat_cnt++.
    - If busreq[owner] = 1 and beat_cnt + 1 < MAX_BEATS: stay in DATA.
    - Otherwise re-arbitrate.
  - ERROR: re-arbitrate, excluding the owner for one decision.
  - RETRY: re-arbitrate with the owner still eligible. Under fixed priority this regrants the same master if it has the highest priority.
  - SPLIT: set split_mask[owner] and re-arbitrate.
- Re-arbitration result:
  - Winner exists: go to ADDR with the new grant; no idle gap.
  - No winner: go to IDLE, grant = 0, grant_id holds its last value.
- Beat limit reached with no other eligible master: the same owner is regranted via ADDR.
- split_clr[i] clears split_mask[i] on the next edge. If a SPLIT set and a split_clr for the same master occur in the same cycle, the set wins.
- All masters split or no requests: stay in IDLE with grant = 0.
- Owner drops busreq mid-tenure: the current beat completes, then re-arbitrate.
- rst asserted mid-transfer: takes effect on the next edge regardless of hready; split_mask is cleared.
- Invariant: grant is one-hot or zero; grant[grant_id] = 1 whenever bus_busy = 1.

Optional Feature:
- Macro ARB_ROUND_ROBIN_EN.
- Defined:
  - arb_pick searches from rr_ptr upward, modulo N_MASTERS.
  - rr_ptr = winner + 1 (wrapping to 0) on every grant.
  - The RETRY owner goes to the lowest priority.
- Undefined: fixed priority with master 0 highest; rr_ptr is not implemented.

Decomposition:
- ahb_pkg:
  - HRESP codes OKAY/ERROR/RETRY/SPLIT.
  - Arbiter state encoding IDLE/ADDR/DATA.
  - MAX_N_MASTERS = 8.
- Sub-module arb_pick: combinational winner select.
  - Inputs: elig, exclude mask, rr_ptr.
  - Outputs: one-hot winner, winner index, valid.
- The top level holds the FSM, beat_cnt, split_mask and rr_ptr.

Test Plan:
1. N=2, busreq = 11, hready = 1, hresp = OKAY:
   - grant = 01 the cycle after request.
   - After 4 DATA beats, grant = 10 via ADDR.
   - Fixed priority: master 0 regains the bus after master 1's tenure.
2. N=4, master 2 granted, hresp = SPLIT with hready = 1:
   - split_mask = 0100; grant moves to the next eligible master.
   - split_clr[2] pulse: split_mask = 0000 next cycle, then master 2 is regranted.
3. hready held low 3 cycles in DATA: grant, grant_id and beat_cnt frozen; the beat counts once hready rises.
4. hresp = ERROR with busreq = 0011 and owner 0: next grant = 0010. Owner 0 is regranted on a later decision.
5. rst = 1 mid-DATA with split_mask = 0001: next edge grant = 0, bus_busy = 0, split_mask = 0.
6. ARB_ROUND_ROBIN_EN, N=3, busreq = 111, MAX_BEATS = 1: grant sequence 001, 010, 100, 001.
